// File: rtl/drv_seq_pkg.sv
// rtl/drv_seq_pkg.sv - shared types and constants for the driver program sequencer
package drv_seq_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } seq_state_t;

    // Byte step between consecutive burst addresses
    localparam int DRV_ADDR_STRIDE = 4;

    // Counter width shared with the control register block
    localparam int DRV_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable counter that saturates at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next value: clear wins over increment, increment stops at all-ones
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - pops vector addresses and issues throttled fetch requests
module program_sequencer
    import drv_seq_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int ADDR_STRIDE = DRV_ADDR_STRIDE,
    parameter int CNT_W       = DRV_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_program,
    input  logic              end_program,
    input  logic              abort_program,
    input  logic              freeze_addr_fifo,
    input  logic              send_consec_addr,
    input  logic [7:0]        consec_count,
    input  logic [15:0]       vector_fifo_threshold,
    input  logic [15:0]       words_in_vctr_fifo,
    input  logic              vector_fifo_full,
    input  logic              addr_fifo_empty,
    input  logic [ADDR_W-1:0] addr_fifo_dout,
    output logic              addr_fifo_rd,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    output logic              active_program,
    output logic              program_done,
    output logic              program_aborted,
    output logic [CNT_W-1:0]  issue_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [7:0]        burst_left_q, burst_left_d;
    logic              run_d_q;
    logic              abort_pend_q, abort_pend_d;
    logic              req_valid_q, req_valid_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              active_q, active_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic              stall_clr;
    logic              stall_inc;
    logic              start;
    logic              abort_any;
    logic              throttle;

    assign start     = run_program & ~run_d_q;
    assign abort_any = abort_pend_q | abort_program;
    assign throttle  = vector_fifo_full | (words_in_vctr_fifo >= vector_fifo_threshold);

    // Next-state and output decode
    always_comb begin
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        burst_left_d    = burst_left_q;
        abort_pend_d    = abort_pend_q;
        req_valid_d     = req_valid_q;
        req_addr_d      = req_addr_q;
        active_d        = active_q;
        issue_cnt_d     = issue_cnt_q;
        stall_clr       = 1'b0;
        stall_inc       = 1'b0;
        addr_fifo_rd    = 1'b0;
        program_done    = 1'b0;
        program_aborted = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = FETCH;
                    issue_cnt_d = '0;
                    stall_clr   = 1'b1;
                    active_d    = 1'b1;
                end
            end

            FETCH: begin
                if (abort_any) begin
                    state_d = ABORT;
                end else if (freeze_addr_fifo) begin
                    state_d = FETCH;
                end else if (addr_fifo_empty && end_program) begin
                    state_d = DONE;
                end else if (addr_fifo_empty) begin
                    state_d = FETCH;
                end else begin
                    addr_fifo_rd = 1'b1;
                    cur_addr_d   = addr_fifo_dout;
                    burst_left_d = send_consec_addr ? consec_count : 8'd0;
                    state_d      = ISSUE;
                end
            end

            ISSUE: begin
                if (!req_valid_q) begin
                    if (abort_any) begin
                        state_d = ABORT;
                    end else if (throttle) begin
                        stall_inc = 1'b1;
                    end else begin
                        req_valid_d = 1'b1;
                        req_addr_d  = cur_addr_q;
                    end
                end else if (req_ready) begin
                    req_valid_d = 1'b0;
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    if (abort_any) begin
                        state_d = ABORT;
                    end else if (burst_left_q == 8'd0) begin
                        state_d = FETCH;
                    end else begin
                        cur_addr_d   = cur_addr_q + ADDR_W'(ADDR_STRIDE);
                        burst_left_d = burst_left_q - 8'd1;
                    end
                end else if (abort_program) begin
                    // Request is committed; remember the abort until it is accepted
                    abort_pend_d = 1'b1;
                end
            end

            DONE: begin
                program_done = 1'b1;
                active_d     = 1'b0;
                state_d      = IDLE;
            end

            ABORT: begin
                program_aborted = 1'b1;
                active_d        = 1'b0;
                abort_pend_d    = 1'b0;
                state_d         = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            burst_left_q <= '0;
            // A run level held through reset must not look like a fresh edge
            run_d_q      <= 1'b1;
            abort_pend_q <= 1'b0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            active_q     <= 1'b0;
            issue_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            burst_left_q <= burst_left_d;
            run_d_q      <= run_program;
            abort_pend_q <= abort_pend_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            active_q     <= active_d;
            issue_cnt_q  <= issue_cnt_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (stall_clr),
        .inc_i   (stall_inc),
        .count_o (stall_cnt)
    );

    assign req_valid      = req_valid_q;
    assign req_addr       = req_addr_q;
    assign active_program = active_q;
    assign issue_cnt      = issue_cnt_q;

endmodule
